vending_controller_n: RTL and testbench

// N-channel vending machine controller: item selection from a decoded keypad, coin credit accumulation,
// per-item stock counters, motor dispense confirmed by IR sensor, change/refund output and fault handling.

---
 rtl/vending_controller_n_if.sv | 21 ++
 rtl/vending_controller_n.sv | 184 ++++++++++++++++++
 tb/tb_vending_controller_n.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/vending_controller_n_if.sv
// Front-end bus: keypad and coin strobes in, coin-reject and change/refund pulses out.
interface vending_controller_n_if #(
    parameter int CREDIT_W = 8
);
    logic                key_valid;
    logic [3:0]          key_code;
    logic                coin_valid;
    logic [CREDIT_W-1:0] coin_value;
    logic                coin_reject;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;

    modport master (
        output key_valid, key_code, coin_valid, coin_value,
        input  coin_reject, change_valid, change_amt
    );
    modport slave (
        input  key_valid, key_code, coin_valid, coin_value,
        output coin_reject, change_valid, change_amt
    );
endinterface

// File: rtl/vending_controller_n.sv
// N-channel vending controller: selection, coin credit, per-item stock, IR-confirmed dispense,
// change/refund pulses and error handling with inactivity and dispense timeouts.
module vending_controller_n #(
    parameter int NUM_ITEMS    = 4,
    parameter int STOCK_W      = 4,
    parameter int INIT_STOCK   = 3,
    parameter int CREDIT_W     = 8,
    parameter int PRICE_BASE   = 10,
    parameter int PRICE_STEP   = 5,
    parameter int SEL_TIMEOUT  = 1000,
    parameter int DISP_TIMEOUT = 500,
    parameter int BEEP_CYCLES  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pushbutton,
    input  logic                 IR_Sensor,
    input  logic                 restock,
    vending_controller_n_if.slave bus,
    output logic [6:0]           seven_seg,
    output logic                 red_led,
    output logic [NUM_ITEMS-1:0] green_leds,
    output logic [NUM_ITEMS-1:0] DC_motor,
    output logic                 buzzer
);
    localparam logic [3:0] KEY_CANCEL = 4'hA;
    localparam int         TMR_W      = 16;

    typedef enum logic [2:0] {IDLE, SELECT, PAY, DISPENSE, ERROR} state_t;

    state_t                             state, state_n;
    logic                               pb_q;
    logic [CREDIT_W-1:0]                credit, credit_n, change, change_n;
    logic [CREDIT_W-1:0]                credit_add, chg_amt_n;
    logic [CREDIT_W:0]                  sum;
    logic [3:0]                         sel, sel_n;
    logic [TMR_W-1:0]                   timer, timer_n;
    logic [7:0]                         beep, beep_n;
    logic [NUM_ITEMS-1:0][STOCK_W-1:0]  stock, stock_n;
    logic                               chg_vld_n, pb_edge, cancel, key_ok;

    function automatic logic [CREDIT_W-1:0] price_of(input logic [3:0] s);
        return CREDIT_W'(PRICE_BASE + int'(s) * PRICE_STEP);
    endfunction

    assign pb_edge    = pushbutton & ~pb_q;
    assign cancel     = bus.key_valid && (bus.key_code == KEY_CANCEL);
    assign sum        = {1'b0, credit} + {1'b0, bus.coin_value};
    // Credit saturates at all-ones rather than wrapping.
    assign credit_add = !bus.coin_valid ? credit :
                        sum[CREDIT_W]   ? '1 : sum[CREDIT_W-1:0];

    always_comb begin
        key_ok = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++)
            if (bus.key_code == 4'(i) && stock[i] != '0) key_ok = 1'b1;
    end

    always_comb begin
        state_n   = state;
        credit_n  = credit;
        change_n  = change;
        sel_n     = sel;
        stock_n   = stock;
        timer_n   = timer + 1'b1;
        beep_n    = (beep != '0) ? beep - 1'b1 : '0;
        chg_vld_n = 1'b0;
        chg_amt_n = bus.change_amt;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (restock)
                    for (int i = 0; i < NUM_ITEMS; i++) stock_n[i] = STOCK_W'(INIT_STOCK);
                if (pb_edge) state_n = SELECT;
            end
            SELECT: begin
                if (bus.key_valid || bus.coin_valid) timer_n = '0;
                if (cancel) state_n = IDLE;
                else if (bus.key_valid && bus.key_code < 4'(NUM_ITEMS)) begin
                    if (key_ok) begin
                        sel_n   = bus.key_code;
                        state_n = PAY;
                    end else beep_n = 8'(BEEP_CYCLES);
                end else if (timer >= TMR_W'(SEL_TIMEOUT)) state_n = IDLE;
            end
            PAY: begin
                credit_n = credit_add;
                if (bus.key_valid || bus.coin_valid) timer_n = '0;
                if (cancel || timer >= TMR_W'(SEL_TIMEOUT)) begin
                    chg_vld_n = 1'b1;
                    chg_amt_n = credit_add;
                    credit_n  = '0;
                    state_n   = IDLE;
                end else if (credit >= price_of(sel)) begin
                    // A coin landing on the transition cycle is kept and folded into the change.
                    change_n = credit_add - price_of(sel);
                    timer_n  = '0;
                    state_n  = DISPENSE;
                end
            end
            DISPENSE: begin
                if (IR_Sensor) begin
                    for (int i = 0; i < NUM_ITEMS; i++)
                        if (sel == 4'(i) && stock[i] != '0) stock_n[i] = stock[i] - 1'b1;
                    chg_vld_n = 1'b1;
                    chg_amt_n = change;
                    credit_n  = '0;
                    state_n   = IDLE;
                end else if (timer >= TMR_W'(DISP_TIMEOUT)) begin
                    chg_vld_n = 1'b1;
                    chg_amt_n = credit;
                    credit_n  = '0;
                    state_n   = ERROR;
                end
            end
            ERROR: begin
                timer_n = '0;
                if (pb_edge) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            pb_q             <= 1'b0;
            credit           <= '0;
            change           <= '0;
            sel              <= '0;
            timer            <= '0;
            beep             <= '0;
            for (int i = 0; i < NUM_ITEMS; i++) stock[i] <= STOCK_W'(INIT_STOCK);
            bus.coin_reject  <= 1'b0;
            bus.change_valid <= 1'b0;
            bus.change_amt   <= '0;
        end else begin
            state            <= state_n;
            pb_q             <= pushbutton;
            credit           <= credit_n;
            change           <= change_n;
            sel              <= sel_n;
            timer            <= timer_n;
            beep             <= beep_n;
            stock            <= stock_n;
            bus.coin_reject  <= bus.coin_valid && (state != PAY);
            bus.change_valid <= chg_vld_n;
            bus.change_amt   <= chg_amt_n;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            green_leds[i] = (stock[i] != '0);
            DC_motor[i]   = (state == DISPENSE) && (sel == 4'(i));
        end
    end

    assign red_led = (state == ERROR);
    assign buzzer  = (state == ERROR) || (beep != '0);

    always_comb begin
        seven_seg = 7'h00;
        case (state)
            SELECT: seven_seg = 7'h40;
            ERROR:  seven_seg = 7'h79;
            PAY, DISPENSE:
                case (sel)
                    4'd0: seven_seg = 7'h3F;
                    4'd1: seven_seg = 7'h06;
                    4'd2: seven_seg = 7'h5B;
                    4'd3: seven_seg = 7'h4F;
                    4'd4: seven_seg = 7'h66;
                    4'd5: seven_seg = 7'h6D;
                    4'd6: seven_seg = 7'h7D;
                    4'd7: seven_seg = 7'h07;
                    4'd8: seven_seg = 7'h7F;
                    4'd9: seven_seg = 7'h6F;
                    default: seven_seg = 7'h00;
                endcase
            default: seven_seg = 7'h00;
        endcase
    end
endmodule

// File: tb/tb_vending_controller_n.sv
// Directed bench for vending_controller_n with hand-computed expectations.
module tb_vending_controller_n;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       pushbutton = 1'b0;
    logic       IR_Sensor = 1'b0;
    logic       restock = 1'b0;
    logic [6:0] seven_seg;
    logic       red_led, buzzer;
    logic [3:0] green_leds, DC_motor;
    int         checks = 0;
    int         errors = 0;
    int         n;

    vending_controller_n_if #(.CREDIT_W(8)) bus();

    vending_controller_n dut (
        .clk(clk), .reset(reset), .pushbutton(pushbutton), .IR_Sensor(IR_Sensor),
        .restock(restock), .bus(bus), .seven_seg(seven_seg), .red_led(red_led),
        .green_leds(green_leds), .DC_motor(DC_motor), .buzzer(buzzer)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press();
        pushbutton = 1'b1; tick(); pushbutton = 1'b0; tick();
    endtask

    task automatic key(input logic [3:0] k);
        bus.key_valid = 1'b1; bus.key_code = k; tick(); bus.key_valid = 1'b0;
    endtask

    task automatic coin(input logic [7:0] v);
        bus.coin_valid = 1'b1; bus.coin_value = v; tick(); bus.coin_valid = 1'b0;
    endtask

    task automatic ir_pulse();
        IR_Sensor = 1'b1; tick(); IR_Sensor = 1'b0;
    endtask

    initial begin
        bus.key_valid = 1'b0; bus.key_code = 4'h0;
        bus.coin_valid = 1'b0; bus.coin_value = 8'h00;

        // Reset
        repeat (3) tick();
        chk("rst_seg", 32'(seven_seg), 32'h00);
        chk("rst_green", 32'(green_leds), 32'hF);
        chk("rst_motor", 32'(DC_motor), 32'h0);
        chk("rst_red_buz", {30'd0, red_led, buzzer}, 32'h0);
        chk("rst_change", {23'd0, bus.change_valid, bus.change_amt}, 32'h0);
        reset = 1'b1; tick();

        // Item 2, coins 10+15, change 5
        press();
        chk("sel_seg", 32'(seven_seg), 32'h40);
        key(4'd2);
        chk("pay_seg2", 32'(seven_seg), 32'h5B);
        coin(8'd10); coin(8'd15); tick();
        chk("disp_motor2", 32'(DC_motor), 32'b0100);
        ir_pulse();
        chk("chg_valid2", 32'(bus.change_valid), 32'h1);
        chk("chg_amt2", 32'(bus.change_amt), 32'd5);
        chk("motor_off2", 32'(DC_motor), 32'h0);
        tick();
        chk("chg_pulse_end", 32'(bus.change_valid), 32'h0);
        chk("chg_amt_held", 32'(bus.change_amt), 32'd5);

        // Empty item 0, then reject selection with a beep
        repeat (3) begin
            press(); key(4'd0); coin(8'd10); tick(); ir_pulse(); tick();
        end
        chk("green_e", 32'(green_leds), 32'hE);
        press(); key(4'd0);
        n = 0;
        while (buzzer && n < 50) begin n++; tick(); end
        chk("beep_len", 32'(n), 32'd20);
        chk("beep_stay_sel", 32'(seven_seg), 32'h40);
        key(4'hA);
        chk("cancel_idle", 32'(seven_seg), 32'h00);

        // Inactivity refund of 7
        press(); key(4'd1); coin(8'd7);
        chk("pay_seg1", 32'(seven_seg), 32'h06);
        n = 0;
        while (!bus.change_valid && n < 1100) begin n++; tick(); end
        chk("idle_to_cycles", 32'(n), 32'd1001);
        chk("idle_refund", 32'(bus.change_amt), 32'd7);
        chk("idle_to_seg", 32'(seven_seg), 32'h00);
        coin(8'd3);
        chk("coin_reject", 32'(bus.coin_reject), 32'h1);
        tick();
        chk("coin_reject_end", 32'(bus.coin_reject), 32'h0);

        // Dispense timeout -> ERROR with full refund
        press(); key(4'd1); coin(8'd15); tick();
        chk("disp_motor1", 32'(DC_motor), 32'b0010);
        n = 0;
        while (!red_led && n < 600) begin n++; tick(); end
        chk("disp_to_cycles", 32'(n), 32'd501);
        chk("err_seg", 32'(seven_seg), 32'h79);
        chk("err_refund", {23'd0, bus.change_valid, bus.change_amt}, {23'd0, 1'b1, 8'd15});
        chk("err_motor_buz", {27'd0, DC_motor, buzzer}, 32'h1);
        press();
        chk("err_exit", {24'd0, red_led, seven_seg}, 32'h0);
        chk("err_stock", 32'(green_leds), 32'hE);

        // Saturating credit on item 3
        press(); key(4'd3); coin(8'd200); coin(8'd200);
        chk("sat_motor", 32'(DC_motor), 32'b1000);
        chk("sat_seg", 32'(seven_seg), 32'h4F);
        ir_pulse();
        chk("sat_change", 32'(bus.change_amt), 32'd230);

        // Coin and cancel in the same cycle
        press(); key(4'd1);
        bus.coin_valid = 1'b1; bus.coin_value = 8'd5;
        bus.key_valid = 1'b1; bus.key_code = 4'hA;
        tick();
        bus.coin_valid = 1'b0; bus.key_valid = 1'b0;
        chk("coin_cancel", {23'd0, bus.change_valid, bus.change_amt}, {23'd0, 1'b1, 8'd5});

        // Restock, then reset mid-dispense drops the motor immediately
        restock = 1'b1; tick(); restock = 1'b0;
        chk("restock", 32'(green_leds), 32'hF);
        press(); key(4'd0); coin(8'd10); tick();
        chk("rst_disp_motor", 32'(DC_motor), 32'b0001);
        #2 reset = 1'b0; #1;
        chk("async_motor_off", 32'(DC_motor), 32'h0);
        tick();
        chk("rst_no_refund", 32'(bus.change_valid), 32'h0);
        reset = 1'b1; tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
